srtc_if: RTL
============

SRTC_IF -- requirements
Module: srtc_if

Interface
REQ-001 SHALL have parameters: RTC_WE_CYCLES, default 4, commit-pulse width in clkin cycles; IDX_NONE, default 4'hF, read index meaning "before first nibble".
REQ-002 SHALL use one clock and an asynchronous, active-low reset; ports in this order: clkin input 1 system clock; reset_n input 1 async active-low reset.
REQ-003 enable input 1: S-RTC register window selected.
REQ-004 addr_in input 1: 0 = $2800 read port, 1 = $2801 write port.
REQ-005 data_in input 8: SNES write data (low nibble used).
REQ-006 reg_oe_rising input 1: one-cycle strobe, end of SNES read.
REQ-007 reg_we_rising input 1: one-cycle strobe, end of SNES write.
REQ-008 rtc_data_in input 60: live BCD time from rtc block ([3:0] sec1 ... [55:52] yr1000, [59:56] dow).
REQ-009 data_out output 8: read data for $2800.
REQ-010 rtc_we output 1: commit pulse to rtc we1.
REQ-011 rtc_data_out output 60: time to commit, rtc_data_in format.

Function
REQ-012 Modes SHALL be READY, READ, COMMAND, WRITE; 4-bit index idx; 60-bit snapshot shadow; 13-nibble write buffer wbuf.
REQ-013 A read SHALL occur when enable & !addr_in & reg_oe_rising; a write when enable & addr_in & reg_we_rising; write wins if both in one cycle (read ignored).
REQ-014 Nibble map idx 0..12: sec1, sec10, min1, min10, hour1, hour10, day1, day10, month binary (mon10*10+mon1, 1..12), yr1, yr10, century = (yr1000*10+yr100)-10, dow[2:0].
REQ-015 data_out SHALL be registered, 1-cycle latency from mode/idx/shadow change: mode!=READ -> 8'h00; idx==IDX_NONE or idx>12 -> 8'h0F; else {4'h0, nibble[idx]}.
REQ-016 Read in READ: idx==IDX_NONE -> shadow<=rtc_data_in, idx<=0; idx>12 -> idx<=IDX_NONE; else idx<=idx+1. Read in other modes: no state change.
REQ-017 Write nibble n=data_in[3:0]: n==D -> mode READ, idx IDX_NONE; n==E -> mode COMMAND; n==F -> ignored; otherwise by mode.
REQ-018 COMMAND, n==0 -> mode WRITE, idx 0, wbuf cleared; n==4 -> mode READY, idx IDX_NONE, wbuf cleared; other n -> mode READY.
REQ-019 WRITE, idx<=12 -> wbuf[idx]<=n, idx+1; on the write with idx==12, commit starts; idx>12 -> ignored. READ/READY non-control nibbles ignored.
REQ-020 Commit: rtc_data_out loaded same cycle: BCD fields direct, month binary m -> mon10=(m>=10), mon1=m-10*mon10 (m>12 clamps to 12), century c<=9 -> 19, c==10 -> 20, c>=11 -> 21; dow={1'b0,wbuf[12][2:0]}.
REQ-021 rtc_we SHALL rise the cycle after rtc_data_out load and stay high exactly RTC_WE_CYCLES cycles; rtc_data_out stable from load until the next commit.
REQ-022 A new commit while rtc_we high SHALL restart the pulse with new data; no pulse dropped.
REQ-023 Mode/idx SHALL be unaffected by commit; next read sequence snapshots fresh rtc_data_in.

Reset
REQ-024 On reset_n low, asynchronously: mode READY, idx IDX_NONE, shadow 0, wbuf 0, data_out 8'h00, rtc_we 0, rtc_data_out 0, pulse counter 0.
REQ-025 Reset mid-commit SHALL drop rtc_we immediately; no commit after release.

Structure
REQ-026 Package srtc_pkg SHALL hold mode encoding, command nibbles (D,E,F,0,4), IDX_NONE, field bit offsets, nibble count 13.
REQ-027 One sub-module srtc_bcd_pack SHALL convert wbuf to 60-bit rtc format (REQ-020); rest is one module.

Verification
REQ-028 Reset, write D, 15 reads with rtc_data_in=60'h320241231235959 -> 0F,9,5,9,5,3,2,1,3,C,4,2,A,3 then 0F.
REQ-029 Write E,0, then 1,0,0,0,0,0,1,0,2,5,2,A,4 -> rtc_we high 4 cycles, rtc_data_out=60'h420250201000001.
REQ-030 Change rtc_data_in mid-read-sequence -> remaining nibbles from shadow, unchanged.
REQ-031 Read and write strobe same cycle (write D) -> mode READ, idx IDX_NONE, read ignored.
REQ-032 reset_n low during rtc_we pulse -> rtc_we 0 same cycle, outputs at reset values.
REQ-033 WRITE with month nibble F-bypass (n=F ignored), century 0 -> committed yr1000/yr100=1/9.

Source files
------------

// File: rtl/srtc_pkg.sv
// Shared definitions for the S-RTC register window: mode encoding, command
// nibbles, rtc_data bit layout and the read-side nibble mapping.
package srtc_pkg;

    typedef enum logic [1:0] {
        MODE_READY   = 2'd0,
        MODE_READ    = 2'd1,
        MODE_COMMAND = 2'd2,
        MODE_WRITE   = 2'd3
    } srtc_mode_e;

    localparam logic [3:0] CMD_READ    = 4'hD;
    localparam logic [3:0] CMD_COMMAND = 4'hE;
    localparam logic [3:0] CMD_IGNORE  = 4'hF;
    localparam logic [3:0] CMD_WRITE   = 4'h0;
    localparam logic [3:0] CMD_RESET   = 4'h4;

    localparam logic [3:0] DEF_IDX_NONE = 4'hF;
    localparam int         NIBBLE_CNT   = 13;
    localparam logic [3:0] LAST_IDX     = 4'(NIBBLE_CNT - 1);
    localparam int         RTC_W        = 60;

    // Bit offsets of each BCD field inside rtc_data
    localparam int SEC1_O   = 0;
    localparam int SEC10_O  = 4;
    localparam int MIN1_O   = 8;
    localparam int MIN10_O  = 12;
    localparam int HOUR1_O  = 16;
    localparam int HOUR10_O = 20;
    localparam int DAY1_O   = 24;
    localparam int DAY10_O  = 28;
    localparam int MON1_O   = 32;
    localparam int MON10_O  = 36;
    localparam int YR1_O    = 40;
    localparam int YR10_O   = 44;
    localparam int YR100_O  = 48;
    localparam int YR1000_O = 52;
    localparam int DOW_O    = 56;

    // Nibble slots that differ from a plain BCD digit
    localparam int NIB_MONTH = 8;
    localparam int NIB_CENT  = 11;
    localparam int NIB_DOW   = 12;

    typedef logic [NIBBLE_CNT-1:0][3:0] wbuf_t;

    // Nibble presented to the SNES for a given read index
    function automatic logic [3:0] rtc_nibble(input logic [RTC_W-1:0] t, input logic [3:0] idx);
        logic [7:0] mon;
        logic [7:0] cen;
        mon = 8'(t[MON10_O +: 4]) * 8'd10 + 8'(t[MON1_O +: 4]);
        cen = 8'(t[YR1000_O +: 4]) * 8'd10 + 8'(t[YR100_O +: 4]) - 8'd10;
        case (idx)
            4'd0:    rtc_nibble = t[SEC1_O +: 4];
            4'd1:    rtc_nibble = t[SEC10_O +: 4];
            4'd2:    rtc_nibble = t[MIN1_O +: 4];
            4'd3:    rtc_nibble = t[MIN10_O +: 4];
            4'd4:    rtc_nibble = t[HOUR1_O +: 4];
            4'd5:    rtc_nibble = t[HOUR10_O +: 4];
            4'd6:    rtc_nibble = t[DAY1_O +: 4];
            4'd7:    rtc_nibble = t[DAY10_O +: 4];
            4'd8:    rtc_nibble = mon[3:0];
            4'd9:    rtc_nibble = t[YR1_O +: 4];
            4'd10:   rtc_nibble = t[YR10_O +: 4];
            4'd11:   rtc_nibble = cen[3:0];
            4'd12:   rtc_nibble = t[DOW_O +: 4] & 4'h7;
            default: rtc_nibble = 4'hF;
        endcase
    endfunction

endpackage

// File: rtl/srtc_bcd_pack.sv
// Converts the 13-nibble SNES write buffer into the rtc block's BCD layout,
// expanding the binary month and the century code.
module srtc_bcd_pack
    import srtc_pkg::*;
(
    input  wbuf_t             wbuf,
    output logic [RTC_W-1:0]  rtc_data
);

    logic [3:0] mon;
    logic [3:0] mon1;
    logic       mon10;
    logic [3:0] cen_hi;
    logic [3:0] cen_lo;

    always_comb begin
        mon   = (wbuf[NIB_MONTH] > 4'd12) ? 4'd12 : wbuf[NIB_MONTH];
        mon10 = (mon >= 4'd10);
        mon1  = mon10 ? (mon - 4'd10) : mon;

        // Century code 10 means 20xx; below it is 19xx, above it 21xx
        if (wbuf[NIB_CENT] <= 4'd9) begin
            cen_hi = 4'd1;
            cen_lo = 4'd9;
        end else if (wbuf[NIB_CENT] == 4'd10) begin
            cen_hi = 4'd2;
            cen_lo = 4'd0;
        end else begin
            cen_hi = 4'd2;
            cen_lo = 4'd1;
        end

        rtc_data                  = '0;
        rtc_data[SEC1_O +: 4]     = wbuf[0];
        rtc_data[SEC10_O +: 4]    = wbuf[1];
        rtc_data[MIN1_O +: 4]     = wbuf[2];
        rtc_data[MIN10_O +: 4]    = wbuf[3];
        rtc_data[HOUR1_O +: 4]    = wbuf[4];
        rtc_data[HOUR10_O +: 4]   = wbuf[5];
        rtc_data[DAY1_O +: 4]     = wbuf[6];
        rtc_data[DAY10_O +: 4]    = wbuf[7];
        rtc_data[MON1_O +: 4]     = mon1;
        rtc_data[MON10_O +: 4]    = {3'b000, mon10};
        rtc_data[YR1_O +: 4]      = wbuf[9];
        rtc_data[YR10_O +: 4]     = wbuf[10];
        rtc_data[YR100_O +: 4]    = cen_lo;
        rtc_data[YR1000_O +: 4]   = cen_hi;
        rtc_data[DOW_O +: 4]      = wbuf[NIB_DOW] & 4'h7;
    end

endmodule

// File: rtl/srtc_if.sv
// SNES S-RTC register interface ($2800 read / $2801 write) bridging nibble
// traffic to a 60-bit BCD real-time clock.
module srtc_if #(
    parameter int         RTC_WE_CYCLES = 4,
    parameter logic [3:0] IDX_NONE      = srtc_pkg::DEF_IDX_NONE
) (
    input  logic        clkin,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        addr_in,
    input  logic [7:0]  data_in,
    input  logic        reg_oe_rising,
    input  logic        reg_we_rising,
    input  logic [59:0] rtc_data_in,
    output logic [7:0]  data_out,
    output logic        rtc_we,
    output logic [59:0] rtc_data_out
);
    import srtc_pkg::*;

    localparam int CNT_W = (RTC_WE_CYCLES > 2) ? $clog2(RTC_WE_CYCLES) : 1;

    srtc_mode_e       mode;
    srtc_mode_e       mode_nx;
    logic [3:0]       idx;
    logic [3:0]       idx_nx;
    logic [59:0]      shadow;
    wbuf_t            wbuf;
    wbuf_t            wbuf_pk;
    logic [59:0]      pack_data;
    logic [3:0]       nib;
    logic             wr_stb;
    logic             rd_stb;
    logic             snap;
    logic             wbuf_clr;
    logic             wbuf_wr;
    logic             commit;
    logic             commit_p1;
    logic [CNT_W-1:0] we_cnt;
    logic             unused_data_hi;

    assign nib            = data_in[3:0];
    assign unused_data_hi = ^data_in[7:4];
    assign wr_stb         = enable & addr_in & reg_we_rising;
    assign rd_stb         = enable & ~addr_in & reg_oe_rising & ~wr_stb;

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            mode <= MODE_READY;
            idx  <= IDX_NONE;
        end else begin
            mode <= mode_nx;
            idx  <= idx_nx;
        end
    end

    always_comb begin
        mode_nx  = mode;
        idx_nx   = idx;
        snap     = 1'b0;
        wbuf_clr = 1'b0;
        wbuf_wr  = 1'b0;
        commit   = 1'b0;
        if (wr_stb) begin
            case (nib)
                CMD_READ: begin
                    mode_nx = MODE_READ;
                    idx_nx  = IDX_NONE;
                end
                CMD_COMMAND: mode_nx = MODE_COMMAND;
                CMD_IGNORE:  ;
                default: begin
                    case (mode)
                        MODE_COMMAND: begin
                            if (nib == CMD_WRITE) begin
                                mode_nx  = MODE_WRITE;
                                idx_nx   = 4'd0;
                                wbuf_clr = 1'b1;
                            end else if (nib == CMD_RESET) begin
                                mode_nx  = MODE_READY;
                                idx_nx   = IDX_NONE;
                                wbuf_clr = 1'b1;
                            end else begin
                                mode_nx  = MODE_READY;
                            end
                        end
                        MODE_WRITE: begin
                            if (idx <= LAST_IDX) begin
                                wbuf_wr = 1'b1;
                                idx_nx  = idx + 4'd1;
                                commit  = (idx == LAST_IDX);
                            end
                        end
                        default: ;
                    endcase
                end
            endcase
        end else if (rd_stb && mode == MODE_READ) begin
            // First read of a sequence freezes the time so all nibbles agree
            if (idx == IDX_NONE) begin
                snap   = 1'b1;
                idx_nx = 4'd0;
            end else if (idx > LAST_IDX) begin
                idx_nx = IDX_NONE;
            end else begin
                idx_nx = idx + 4'd1;
            end
        end
    end

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= '0;
            wbuf   <= '0;
        end else begin
            if (snap)
                shadow <= rtc_data_in;
            if (wbuf_clr)
                wbuf <= '0;
            else if (wbuf_wr)
                wbuf[idx] <= nib;
        end
    end

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n)
            data_out <= 8'h00;
        else if (mode != MODE_READ)
            data_out <= 8'h00;
        else if (idx == IDX_NONE || idx > LAST_IDX)
            data_out <= 8'h0F;
        else
            data_out <= {4'h0, rtc_nibble(shadow, idx)};
    end

    // The committing write's nibble is not in wbuf yet, so splice it in
    always_comb begin
        wbuf_pk           = wbuf;
        wbuf_pk[LAST_IDX] = nib;
    end

    srtc_bcd_pack u_pack (
        .wbuf     (wbuf_pk),
        .rtc_data (pack_data)
    );

    // ---- stage p1: data loaded on commit, we pulse starts one cycle later
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            rtc_data_out <= '0;
            commit_p1    <= 1'b0;
            rtc_we       <= 1'b0;
            we_cnt       <= '0;
        end else begin
            commit_p1 <= commit;
            if (commit)
                rtc_data_out <= pack_data;
            if (commit_p1) begin
                rtc_we <= 1'b1;
                we_cnt <= CNT_W'(RTC_WE_CYCLES - 1);
            end else if (we_cnt != '0) begin
                we_cnt <= we_cnt - CNT_W'(1);
            end else begin
                rtc_we <= 1'b0;
            end
        end
    end

endmodule
